ssd_keypad_scan: RTL and testbench
==================================

# ssd_keypad_scan

Parametrised keypad-entry buffer and time-multiplexed seven-segment driver for NUM_DIGITS hex digits. It sits between the keypad decoder (4-bit code plus key-pressed level) and the board SSD pins. It replaces the fixed two-digit toggle/clock-driven chip select with a refresh counter, per-digit valid/blanking, edge-detected key entry, and two entry modes (shift-in and cursor overwrite).

## Interface
Parameters:
- NUM_DIGITS, 2, number of display digits held and scanned; legal range ≥2.
- REFRESH_DIV, 125_000, clk cycles each digit is driven before the scan advances (1 ms at 125 MHz); legal range ≥2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- key_code  in  4  decoded hex value of the current key.
- key_pressed  in  1  level; high while any key is held.
- mode  in  1  0 = shift entry; 1 = cursor overwrite.
- clear  in  1  synchronous clear of digit buffer, cursor and count.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high, registered.
- digit_en  out  NUM_DIGITS  one-hot enable of the scanned digit, registered.
- chip_sel  out  1  bit 0 of the scanned digit index, for the two-digit PmodSSD.
- entry_count  out  $clog2(NUM_DIGITS+1)  written digits, saturating at NUM_DIGITS.

## Operation
- Buffer: NUM_DIGITS entries of {valid, code[3:0]}. Digit 0 is rightmost.
- Key event: key_pressed high while its registered copy (pressed_q) is low. Exactly one event per press, regardless of hold length. key_code is sampled in the event cycle.
- Shift mode (mode=0) on event:
  - digit i ← digit i-1 for i ≥ 1.
  - digit 0 ← {1, key_code}.
  - The oldest digit is discarded.
  - cursor is unchanged.
- Overwrite mode (mode=1) on event:
  - digit[cursor] ← {1, key_code}.
  - cursor ← cursor+1, wrapping from NUM_DIGITS-1 to 0.
- entry_count increments on every event and saturates at NUM_DIGITS.
- clear: all valid bits ← 0, cursor ← 0, entry_count ← 0. Code bits are don't-care. Clear beats a same-cycle key event; that event is dropped, but pressed_q still updates so the held key does not re-fire.
- A mode change takes effect on the next event. Buffer and cursor are preserved.
- Scan counter:
  - Counts 0..REFRESH_DIV-1.
  - On terminal count, the index advances by 1, wrapping NUM_DIGITS-1 → 0.
- Decode (registered each cycle from the buffer entry at the current index):
  - An invalid digit produces seg=0000000 (blank).
  - Valid hex decodes: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- digit_en = one-hot(index) and chip_sel = index[0], registered together with seg so they never disagree.

## Timing
- Reset values: buffer all invalid, cursor 0, entry_count 0, pressed_q 0, scan counter 0, index 0, seg 0000000, digit_en = 1 (digit 0), chip_sel 0.
- rst has priority over clear and key events.
- Event detected at edge t: the buffer is updated at edge t, and seg reflects it at edge t+1 if that digit is currently scanned.
- Index changes at the edge where the counter wraps. seg, digit_en and chip_sel change together one edge later.
- Each digit is driven for exactly REFRESH_DIV cycles. Full frame = NUM_DIGITS × REFRESH_DIV cycles.
- The scan runs continuously and is unaffected by clear, mode and key events.

## Test plan
- Reset: assert rst for 2 cycles with key_pressed=1. Required after release: seg=0000000, digit_en=01, chip_sel=0, entry_count=0, and no event, because pressed_q must see a low first.
- Shift entry, NUM_DIGITS=2, REFRESH_DIV=4:
  - Press 5 and release, then press A.
  - Required: digit0=A and digit1=5.
  - When digit_en=01, seg=1110111; when digit_en=10, seg=1011011.
  - chip_sel toggles every 4 cycles.
  - entry_count=2.
- Overwrite with wrap, NUM_DIGITS=4, mode=1:
  - Press keys 1, 2, 3, 4, 7.
  - Required: digit0=7 (cursor wrapped), digits1..3 = 2, 3, 4; entry_count saturates at 4.
- Held key: hold key_pressed high for 50 cycles with code 3. Required: one event only, entry_count=1.
- Clear concurrent with key edge: clear=1 in the event cycle. Required: all digits blank and entry_count=0. A subsequent press enters normally.
- Blanking and refresh: with one digit written (shift mode, NUM_DIGITS=4, REFRESH_DIV=3):
  - digit_en rotates 0001→0010→0100→1000→0001, each held for 3 cycles.
  - seg is nonzero only while digit_en=0001.

Source files
------------

// File: rtl/ssd_keypad_scan.sv
// -----------------------------------------------------------------------------
// ssd_keypad_scan
//   Keypad-entry buffer plus a time-multiplexed seven-segment driver for
//   NUM_DIGITS hex digits. Key presses are edge-detected and written into
//   the digit buffer, either by shifting in from the right or by overwriting
//   the digit under a wrapping cursor. A refresh counter scans the digits,
//   and each scanned digit is decoded into registered segment and enable
//   outputs. Digits that have not been written are shown blank.
//
// Ports
//   clk          system clock (single domain)
//   rst          synchronous active-high reset
//   key_code     decoded hex value of the current key
//   key_pressed  level, high while any key is held
//   mode         0 = shift entry, 1 = cursor overwrite
//   clear        synchronous clear of valid bits, cursor and entry count
//   seg          segments {a,b,c,d,e,f,g}, active-high, registered
//   digit_en     one-hot enable of the scanned digit, registered
//   chip_sel     bit 0 of the scanned digit index (two-digit PmodSSD)
//   entry_count  number of written digits, saturating at NUM_DIGITS
// -----------------------------------------------------------------------------
module ssd_keypad_scan #(
   parameter int NUM_DIGITS  = 2,
   parameter int REFRESH_DIV = 125_000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [3:0]                        key_code,
   input  logic                              key_pressed,
   input  logic                              mode,
   input  logic                              clear,
   output logic [6:0]                        seg,
   output logic [NUM_DIGITS-1:0]             digit_en,
   output logic                              chip_sel,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_count
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int ENT_W = $clog2(NUM_DIGITS + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
   localparam logic [ENT_W-1:0] FULL_CNT = ENT_W'(NUM_DIGITS);

   logic [NUM_DIGITS-1:0] valid;
   logic [3:0]            code [NUM_DIGITS];
   logic [IDX_W-1:0]      cursor;
   logic [IDX_W-1:0]      scan_idx;
   logic [CNT_W-1:0]      scan_cnt;
   logic                  pressed_q;
   logic                  armed;
   logic                  key_event;
   logic                  take_key;

   // A key that is already held when reset is released must not count as a
   // press: 'armed' only goes high once key_pressed has been seen low.
   assign key_event = key_pressed & ~pressed_q & armed;
   assign take_key  = key_event & ~clear;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // ---- entry control: edge detect, valid bits, cursor, count ----
   always_ff @(posedge clk) begin
      if (rst) begin
         valid       <= '0;
         cursor      <= '0;
         entry_count <= '0;
         pressed_q   <= 1'b0;
         armed       <= 1'b0;
      end else begin
         // pressed_q tracks the key even while clear is high, so a key held
         // through a clear does not fire again afterwards.
         pressed_q <= key_pressed;
         if (!key_pressed) armed <= 1'b1;
         if (clear) begin
            valid       <= '0;
            cursor      <= '0;
            entry_count <= '0;
         end else if (key_event) begin
            if (entry_count != FULL_CNT) entry_count <= entry_count + 1'b1;
            if (mode) begin
               valid[cursor] <= 1'b1;
               cursor        <= (cursor == LAST_IDX) ? '0 : cursor + 1'b1;
            end else begin
               valid <= {valid[NUM_DIGITS-2:0], 1'b1};
            end
         end
      end
   end

   // ---- digit code storage (meaningless while the matching valid is low) ----
   always_ff @(posedge clk) begin
      if (take_key) begin
         if (mode) begin
            code[cursor] <= key_code;
         end else begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) code[i] <= code[i-1];
            code[0] <= key_code;
         end
      end
   end

   // ---- refresh counter and scan index ----
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == LAST_CNT) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // ---- output register: seg, digit_en and chip_sel share one stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         seg      <= '0;
         digit_en <= NUM_DIGITS'(1);
         chip_sel <= 1'b0;
      end else begin
         seg      <= valid[scan_idx] ? hex_to_seg(code[scan_idx]) : 7'b0000000;
         digit_en <= NUM_DIGITS'(1) << scan_idx;
         chip_sel <= scan_idx[0];
      end
   end

endmodule

// File: tb/tb_ssd_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_ssd_keypad_scan
//   Self-checking bench for ssd_keypad_scan. Two instances share the input
//   stimulus: a 2-digit one (REFRESH_DIV=4) and a 4-digit one
//   (REFRESH_DIV=3). Expected {digit_en, seg} pairs are queued when keys are
//   driven and compared once the scan reaches the matching digit.
// -----------------------------------------------------------------------------
module tb_ssd_keypad_scan;

   logic       clk;
   logic       rst;
   logic [3:0] key_code;
   logic       key_pressed;
   logic       mode;
   logic       clear;

   logic [6:0] seg2;
   logic [1:0] en2;
   logic       cs2;
   logic [1:0] cnt2;

   logic [6:0] seg4;
   logic [3:0] en4;
   logic       cs4;
   logic [2:0] cnt4;

   logic       tgt;
   logic [3:0] en_m;
   logic [6:0] seg_m;
   logic       cs_m;

   int passed;
   int total;

   logic [10:0] sb [$];

   localparam logic [6:0] S_BLANK = 7'b0000000;
   localparam logic [6:0] S_3     = 7'b1111001;
   localparam logic [6:0] S_1     = 7'b0110000;
   localparam logic [6:0] S_2     = 7'b1101101;
   localparam logic [6:0] S_4     = 7'b0110011;
   localparam logic [6:0] S_5     = 7'b1011011;
   localparam logic [6:0] S_6     = 7'b1011111;
   localparam logic [6:0] S_7     = 7'b1110000;
   localparam logic [6:0] S_9     = 7'b1111011;
   localparam logic [6:0] S_A     = 7'b1110111;
   localparam logic [6:0] S_E     = 7'b1001111;

   ssd_keypad_scan #(.NUM_DIGITS(2), .REFRESH_DIV(4)) dut2 (
      .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
      .mode(mode), .clear(clear), .seg(seg2), .digit_en(en2),
      .chip_sel(cs2), .entry_count(cnt2)
   );

   ssd_keypad_scan #(.NUM_DIGITS(4), .REFRESH_DIV(3)) dut4 (
      .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
      .mode(mode), .clear(clear), .seg(seg4), .digit_en(en4),
      .chip_sel(cs4), .entry_count(cnt4)
   );

   assign en_m  = tgt ? en4  : {2'b00, en2};
   assign seg_m = tgt ? seg4 : seg2;
   assign cs_m  = tgt ? cs4  : cs2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      total++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
      else
         passed++;
   endtask

   function automatic void push_exp(input logic [3:0] en, input logic [6:0] s);
      sb.push_back({en, s});
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] c, input int hold);
      key_code    = c;
      key_pressed = 1'b1;
      repeat (hold) @(negedge clk);
      key_pressed = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Pop each queued expectation, wait for its digit to be scanned, compare.
   task automatic drain();
      logic [10:0] e;
      int n;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         while (en_m !== e[10:7] && n < 64) begin
            @(negedge clk);
            n++;
         end
         if (n >= 64) begin
            check_val("scan_timeout", 32'(en_m), 32'(e[10:7]));
         end else begin
            check_val("seg", 32'(seg_m), 32'(e[6:0]));
            check_val("chip_sel", 32'(cs_m), 32'(e[8] | e[10]));
         end
      end
   endtask

   task automatic csel_period();
      logic c0;
      int n;
      n  = 0;
      c0 = cs2;
      while (cs2 === c0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         check_val("csel_toggle_timeout", 32'(cs2), 32'(~c0));
      end else begin
         for (int r = 0; r < 2; r++) begin
            n  = 0;
            c0 = cs2;
            while (cs2 === c0 && n < 64) begin
               @(negedge clk);
               n++;
            end
            check_val("csel_period", 32'(n), 32'd4);
            check_val("en_vs_csel", 32'(en2), cs2 ? 32'd2 : 32'd1);
         end
      end
   endtask

   // Sample the 4-digit instance every cycle across one full frame.
   task automatic rot_check();
      logic [3:0]  prev;
      logic [10:0] e;
      int n;
      n    = 0;
      prev = en4;
      @(negedge clk);
      while (!(prev == 4'b1000 && en4 == 4'b0001) && n < 64) begin
         prev = en4;
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         check_val("rot_sync_timeout", 32'(en4), 32'd1);
         sb.delete();
      end else begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("rot_en", 32'(en4), 32'(e[10:7]));
            check_val("rot_seg", 32'(seg4), 32'(e[6:0]));
            @(negedge clk);
         end
      end
   endtask

   initial begin
      passed      = 0;
      total       = 0;
      tgt         = 1'b0;
      rst         = 1'b0;
      key_code    = 4'h0;
      key_pressed = 1'b0;
      mode        = 1'b0;
      clear       = 1'b0;
      @(negedge clk);

      // Reset with a key held throughout: no event may follow.
      key_code    = 4'h8;
      key_pressed = 1'b1;
      do_reset();
      check_val("rst_seg", 32'(seg2), 32'(S_BLANK));
      check_val("rst_digit_en", 32'(en2), 32'd1);
      check_val("rst_chip_sel", 32'(cs2), 32'd0);
      check_val("rst_count", 32'(cnt2), 32'd0);
      check_val("rst_digit_en4", 32'(en4), 32'd1);
      repeat (5) @(negedge clk);
      check_val("held_through_rst_count", 32'(cnt2), 32'd0);
      check_val("held_through_rst_count4", 32'(cnt4), 32'd0);
      key_pressed = 1'b0;
      @(negedge clk);
      push_exp(4'b0001, S_BLANK);
      push_exp(4'b0010, S_BLANK);
      drain();

      // Shift entry on the 2-digit instance: 5 then A.
      mode = 1'b0;
      do_reset();
      press(4'h5, 3);
      press(4'hA, 3);
      push_exp(4'b0001, S_A);
      push_exp(4'b0010, S_5);
      drain();
      check_val("shift_count", 32'(cnt2), 32'd2);
      csel_period();

      // Held key: one event only.
      do_reset();
      press(4'h3, 50);
      check_val("held_count", 32'(cnt2), 32'd1);
      push_exp(4'b0001, S_3);
      push_exp(4'b0010, S_BLANK);
      drain();

      // Clear in the same cycle as a key edge: clear wins, no re-fire.
      key_code    = 4'hC;
      key_pressed = 1'b1;
      clear       = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (3) @(negedge clk);
      key_pressed = 1'b0;
      repeat (2) @(negedge clk);
      check_val("clear_count", 32'(cnt2), 32'd0);
      push_exp(4'b0001, S_BLANK);
      push_exp(4'b0010, S_BLANK);
      drain();
      press(4'h9, 2);
      check_val("after_clear_count", 32'(cnt2), 32'd1);
      push_exp(4'b0001, S_9);
      push_exp(4'b0010, S_BLANK);
      drain();

      // Overwrite with cursor wrap on the 4-digit instance.
      tgt  = 1'b1;
      mode = 1'b1;
      do_reset();
      press(4'h1, 2);
      press(4'h2, 2);
      press(4'h3, 2);
      press(4'h4, 2);
      press(4'h7, 2);
      check_val("ovw_count_sat", 32'(cnt4), 32'd4);
      push_exp(4'b0001, S_7);
      push_exp(4'b0010, S_2);
      push_exp(4'b0100, S_3);
      push_exp(4'b1000, S_4);
      drain();

      // Blanking and refresh rotation with a single shifted-in digit.
      mode = 1'b0;
      do_reset();
      press(4'hE, 2);
      for (int k = 0; k < 12; k++)
         push_exp(4'(1 << (k / 3)), (k < 3) ? S_E : S_BLANK);
      rot_check();
      check_val("rot_count", 32'(cnt4), 32'd1);

      // Mode change keeps buffer and cursor: overwrite lands on digit 0.
      mode = 1'b1;
      press(4'h6, 2);
      check_val("mode_chg_count", 32'(cnt4), 32'd2);
      push_exp(4'b0001, S_6);
      push_exp(4'b0010, S_BLANK);
      push_exp(4'b0100, S_BLANK);
      push_exp(4'b1000, S_BLANK);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
